// File: rtl/rule110_pkg.sv
// rule110_pkg: shared constants, host FSM states and the rule-110 step function
package rule110_pkg;
  localparam int WIDTH = 512;
  localparam int WORD = 32;
  localparam int NWORDS = WIDTH / WORD;
  localparam int GEN_W = 16;
  typedef enum logic [1:0] {FILL, LOAD, RUN, DRAIN} state_t;
  // left neighbour of cell i is i+1, right is i-1; cells beyond either end read as 0
  function automatic logic [WIDTH-1:0] rule110_next(input logic [WIDTH-1:0] q);
    return (q ^ (q << 1)) | (q & ~(q >> 1));
  endfunction
endpackage

// File: rtl/rule110_ca.sv
// rule110_ca: free-running 512-cell rule-110 automaton with synchronous load, no reset
module rule110_ca
  import rule110_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) q <= load ? data : rule110_next(q);
endmodule

// File: rtl/rule110_host.sv
// rule110_host: gathers a seed from a word stream, loads the automaton, runs it for
// a programmed number of generations, then streams the snapshot back out as words
module rule110_host #(
  parameter int WIDTH = 512,
  parameter int WORD = 32,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  input  logic [GEN_W-1:0] gens,
  output logic             ca_load,
  output logic [WIDTH-1:0] ca_data,
  input  logic [WIDTH-1:0] ca_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             busy
);
  import rule110_pkg::*;
  localparam int NW = WIDTH / WORD;
  localparam int IW = $clog2(NW);
  state_t state, state_nx;
  logic [IW-1:0] word_idx;
  logic [GEN_W-1:0] gen_cnt;
  logic [WIDTH-1:0] seed, snapshot;
  logic last, in_acc, out_acc;
  assign last = word_idx == IW'(NW - 1);
  assign in_acc = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  assign ca_data = seed;
  always_comb begin
    state_nx = state;
    in_ready = state == FILL;
    ca_load = state == LOAD;
    out_valid = state == DRAIN;
    busy = state != FILL;
    out_last = out_valid & last;
    out_data = out_valid ? snapshot[word_idx*WORD +: WORD] : '0;
    if (state == FILL && in_acc && last) state_nx = LOAD;
    if (state == LOAD) state_nx = RUN;
    if (state == RUN && gen_cnt == '0) state_nx = DRAIN;
    if (state == DRAIN && out_acc && last) state_nx = FILL;
  end
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= FILL;
      word_idx <= '0;
      gen_cnt <= '0;
      seed <= '0;
      snapshot <= '0;
    end else begin
      state <= state_nx;
      if (state == FILL && in_acc) begin
        seed[word_idx*WORD +: WORD] <= in_data;
        word_idx <= word_idx + 1'b1;
        if (last) gen_cnt <= gens;
      end
      // the snapshot is taken on the cycle the count is already zero, so RUN lasts gens+1 cycles
      if (state == RUN) begin
        if (gen_cnt != '0) gen_cnt <= gen_cnt - 1'b1;
        else snapshot <= ca_q;
      end
      if (state == DRAIN && out_acc) word_idx <= word_idx + 1'b1;
    end
  end
endmodule

// File: doc/rule110_host.md
Name: rule110_host

Overview:
- Host-side driver for the 512-cell rule-110 automaton; it sits at the other end of the automaton's load/data/q interface.
- Assembles a seed from a 32-bit valid/ready word stream, then drives load/data for one cycle.
- Lets the free-running automaton advance a programmed number of generations, snapshots q, and streams the snapshot back out as 32-bit words.
- Sits between the system bus word streams and the automaton instance.

Parameters:
- WIDTH, 512, automaton cell count (must equal the automaton's data/q width).
- WORD, 32, stream word width; WIDTH must be a multiple of WORD.
- GEN_W, 16, width of the generation count.

Ports:
- clk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- in_valid  in  1  seed word valid
- in_ready  out  1  seed word accepted when in_valid & in_ready
- in_data  in  WORD  seed word; word k maps to seed bits [k*WORD+WORD-1 : k*WORD], word 0 first
- gens  in  GEN_W  generations to run; sampled on the edge that accepts the last seed word
- ca_load  out  1  drives automaton load
- ca_data  out  WIDTH  drives automaton data; always equals the seed register
- ca_q  in  WIDTH  automaton q
- out_valid  out  1  result word valid
- out_ready  in  1  result word consumed when out_valid & out_ready
- out_data  out  WORD  result word; word 0 (bits 31:0) first
- out_last  out  1  high with the final word (word NWORDS-1)
- busy  out  1  high in any state other than FILL

Behaviour:
- Derived constant: NWORDS = WIDTH/WORD = 16.
- FSM states: FILL, LOAD, RUN, DRAIN.
- FILL:
  - in_ready=1. Each accepted word is written into the seed register at slot word_idx, then word_idx increments.
  - Gaps in in_valid are allowed.
  - On accepting word NWORDS-1: latch gens into gen_cnt, clear word_idx, go to LOAD.
- LOAD (exactly 1 cycle):
  - ca_load=1. The automaton takes q=seed at the end of this cycle. Go to RUN.
- RUN:
  - ca_load=0; the automaton steps every cycle.
  - If gen_cnt != 0: decrement it and stay in RUN.
  - If gen_cnt == 0: snapshot <= ca_q, which is generation gens, and go to DRAIN.
  - RUN therefore lasts gens+1 cycles.
- DRAIN:
  - out_valid=1, out_data=snapshot word word_idx, out_last=(word_idx==NWORDS-1).
  - While out_ready=0, out_data and out_last hold stable.
  - On the last word's handshake: clear word_idx and go to FILL. in_ready rises the following cycle; there is no same-cycle overlap.
- Latency: counting the edge that accepts the last seed word as edge 0, out_valid is first high after edge gens+2.
- ca_load is 0 in every state except LOAD.
- in_valid outside FILL is ignored (in_ready=0).
- A change to gens after sampling has no effect.
- gens=0 is legal: the snapshot is the seed itself.
- gens=2^GEN_W-1 is legal: there is no wrap, and the count ends at 0.
- Reset (asynchronous, any state, including mid-RUN or mid-DRAIN):
  - State=FILL, word_idx=0, gen_cnt=0, seed=0, snapshot=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, ca_load=0, busy=0, out_data=0.
  - A partial seed is discarded.
  - The automaton itself has no reset; its q is don't-care until the next LOAD.
- Width rules:
  - word_idx is $clog2(NWORDS) bits.
  - gen_cnt is GEN_W bits, unsigned.

Decomposition:
- Shared package rule110_pkg:
  - WIDTH, WORD, NWORDS constants.
  - FSM state enum.
  - Function rule110_next(logic [WIDTH-1:0]) as the bench golden model. It uses zero boundary cells at both ends, with no wrap.
- Single module; no sub-module needed.
- The bench instantiates the automaton alongside rule110_host and connects ca_* to it.

Test Plan:
1. Seed word0=0x00000001, all other words 0, gens=0 -> 16 output words: word0=0x00000001, rest 0; out_last only on word 15.
2. Same seed, gens=1 -> word0=0x00000003. gens=2 -> 0x00000007. gens=3 -> 0x0000000D.
3. Seed word15=0x80000000 (bit 511 only), gens=1 -> word15=0x80000000, all others 0. This checks the zero boundary at the top: no wrap to bit 0.
4. gens=5 with in_valid gapped during FILL and out_ready toggled 1010... in DRAIN -> out_valid first high after edge 7 following the last accept. out_data is stable while stalled, exactly 16 words are emitted, and in_ready returns 1 the cycle after the last handshake.
5. gens=1000, areset_n pulsed low mid-RUN -> all outputs immediately take their reset values. A fresh seed (test 1 values) then produces the correct result.
6. Random seed, gens=37 -> all 16 output words match rule110_next applied 37 times.
